instr_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the 4-bit CPU datapath. It supersedes the purely combinational opcode decoder. It fetches each instruction word over a request/acknowledge handshake and decodes it into registered control strobes. It also keeps the carry flag, resolves conditional and unconditional jumps, and supports a HALT state. The block sits between the program ROM/PC and the A/B/IO/PC register and ALU datapath.

---
 rtl/instr_sequencer_if.sv | 22 ++
 rtl/instr_sequencer.sv | 155 +++++++++++++++
 tb/tb_instr_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Instruction-fetch handshake between the sequencer (master) and the program ROM (slave).
// The instruction word carries the opcode in its upper OP_W bits and the immediate below it.
interface instr_sequencer_if #(
  parameter int IMM_W = 4,
  parameter int OP_W  = 4
) ();
  logic                    fetch_req;
  logic                    fetch_ack;
  logic [OP_W+IMM_W-1:0]   instr;

  modport master (
    output fetch_req,
    input  fetch_ack,
    input  instr
  );

  modport slave (
    input  fetch_req,
    output fetch_ack,
    output instr
  );
endinterface

// File: rtl/instr_sequencer.sv
// FETCH/DECODE/EXEC/HALT controller for the 4-bit CPU datapath: fetches an instruction,
// decodes it into registered one-cycle control strobes, tracks carry and resolves jumps.
module instr_sequencer #(
  parameter int IMM_W = 4,
  parameter int OP_W  = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  instr_sequencer_if.master fetch,
  input  logic              alu_carry,
  output logic [1:0]        alu_data_sel,
  output logic [IMM_W-1:0]  imm,
  output logic              reg_a_load,
  output logic              reg_b_load,
  output logic              reg_io_load,
  output logic              reg_pc_load,
  output logic              pc_inc,
  output logic              carry_flag,
  output logic              halted
);

  localparam int IW = OP_W + IMM_W;

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  logic [1:0]       state_reg, state_next;
  logic [IW-1:0]    ir_reg;
  logic             fetch_req_reg;
  logic [1:0]       sel_reg;
  logic [IMM_W-1:0] imm_reg;
  logic             a_load_reg, b_load_reg, io_load_reg, pc_load_reg, pc_inc_reg;
  logic             carry_reg;
  logic             halted_reg;

  logic [3:0]       op4;
  logic             upper_nz;
  logic             fetch_take;

  logic [1:0]       dec_sel;
  logic             dec_a, dec_b, dec_io, dec_pc, dec_inc, dec_halt;

  assign op4 = ir_reg[IMM_W+3:IMM_W];

  // Wider opcode fields only decode when the extra upper bits are all zero.
  generate
    if (OP_W > 4) begin : g_wide_op
      assign upper_nz = |ir_reg[IW-1:IMM_W+4];
    end else begin : g_narrow_op
      assign upper_nz = 1'b0;
    end
  endgenerate

  // The ROM is only listened to once the registered request is actually visible.
  assign fetch_take = (state_reg == ST_FETCH) && fetch_req_reg && fetch.fetch_ack;

  always_comb begin
    dec_sel  = SEL_ZERO;
    dec_a    = 1'b0;
    dec_b    = 1'b0;
    dec_io   = 1'b0;
    dec_pc   = 1'b0;
    dec_halt = 1'b0;
    if (!upper_nz) begin
      case (op4)
        4'b0000: begin dec_sel = SEL_A;    dec_a  = 1'b1; end
        4'b0001: begin dec_sel = SEL_B;    dec_a  = 1'b1; end
        4'b0010: begin dec_sel = SEL_IN;   dec_a  = 1'b1; end
        4'b0011: begin dec_sel = SEL_ZERO; dec_a  = 1'b1; end
        4'b0100: begin dec_sel = SEL_A;    dec_b  = 1'b1; end
        4'b0101: begin dec_sel = SEL_B;    dec_b  = 1'b1; end
        4'b0110: begin dec_sel = SEL_IN;   dec_b  = 1'b1; end
        4'b0111: begin dec_sel = SEL_ZERO; dec_b  = 1'b1; end
        4'b1001: begin dec_sel = SEL_B;    dec_io = 1'b1; end
        4'b1011: begin dec_sel = SEL_ZERO; dec_io = 1'b1; end
        // JNC sees the flag left by the previous instruction's EXEC.
        4'b1110: begin dec_sel = SEL_ZERO; dec_pc = ~carry_reg; end
        4'b1111: begin dec_sel = SEL_ZERO; dec_pc = 1'b1; end
        4'b1000: dec_halt = 1'b1;
        default: dec_sel = SEL_ZERO;
      endcase
    end
    dec_inc = ~dec_pc & ~dec_halt;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH:  if (fetch_take) state_next = ST_DECODE;
      ST_DECODE: state_next = dec_halt ? ST_HALT : ST_EXEC;
      ST_EXEC:   state_next = ST_FETCH;
      default:   state_next = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg     <= ST_FETCH;
      ir_reg        <= '0;
      fetch_req_reg <= 1'b0;
      sel_reg       <= SEL_ZERO;
      imm_reg       <= '0;
      a_load_reg    <= 1'b0;
      b_load_reg    <= 1'b0;
      io_load_reg   <= 1'b0;
      pc_load_reg   <= 1'b0;
      pc_inc_reg    <= 1'b0;
      carry_reg     <= 1'b0;
      halted_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fetch_req_reg <= (state_next == ST_FETCH);
      halted_reg    <= (state_next == ST_HALT);

      if (fetch_take) begin
        ir_reg <= fetch.instr;
      end

      if (state_reg == ST_DECODE) begin
        sel_reg <= dec_sel;
        imm_reg <= ir_reg[IMM_W-1:0];
      end

      // Strobes are registered on the DECODE->EXEC edge so they live exactly in EXEC.
      a_load_reg  <= (state_reg == ST_DECODE) && dec_a;
      b_load_reg  <= (state_reg == ST_DECODE) && dec_b;
      io_load_reg <= (state_reg == ST_DECODE) && dec_io;
      pc_load_reg <= (state_reg == ST_DECODE) && dec_pc;
      pc_inc_reg  <= (state_reg == ST_DECODE) && dec_inc;

      if (state_reg == ST_EXEC) begin
        carry_reg <= alu_carry;
      end
    end
  end

  assign fetch.fetch_req = fetch_req_reg;
  assign alu_data_sel    = sel_reg;
  assign imm             = imm_reg;
  assign reg_a_load      = a_load_reg;
  assign reg_b_load      = b_load_reg;
  assign reg_io_load     = io_load_reg;
  assign reg_pc_load     = pc_load_reg;
  assign pc_inc          = pc_inc_reg;
  assign carry_flag      = carry_reg;
  assign halted          = halted_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a ROM driver pushes expected EXEC-cycle outputs to a
// scoreboard queue, and a negedge monitor pops and compares them when a strobe cycle appears.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       alu_carry;
  logic [1:0] alu_data_sel;
  logic [3:0] imm;
  logic       reg_a_load, reg_b_load, reg_io_load, reg_pc_load, pc_inc;
  logic       carry_flag, halted;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_exec   = -1;
  int prev_exec   = -1;
  int exec_n      = 0;

  logic [10:0] sb_q[$];

  instr_sequencer_if #(.IMM_W(4), .OP_W(4)) bus ();

  instr_sequencer #(.IMM_W(4), .OP_W(4)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .fetch        (bus),
    .alu_carry    (alu_carry),
    .alu_data_sel (alu_data_sel),
    .imm          (imm),
    .reg_a_load   (reg_a_load),
    .reg_b_load   (reg_b_load),
    .reg_io_load  (reg_io_load),
    .reg_pc_load  (reg_pc_load),
    .pc_inc       (pc_inc),
    .carry_flag   (carry_flag),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [1:0] sel, input logic [3:0] im,
                                     input logic a, input logic b, input logic io,
                                     input logic pc, input logic inc);
    return {sel, im, a, b, io, pc, inc};
  endfunction

  function automatic logic [10:0] obs_exec();
    return {alu_data_sel, imm, reg_a_load, reg_b_load, reg_io_load, reg_pc_load, pc_inc};
  endfunction

  function automatic logic [13:0] obs_all();
    return {bus.fetch_req, alu_data_sel, imm, reg_a_load, reg_b_load, reg_io_load,
            reg_pc_load, pc_inc, carry_flag, halted};
  endfunction

  // Scoreboard monitor: an EXEC cycle is any cycle with pc_inc or reg_pc_load high.
  always @(negedge clk) begin
    if (n_reset === 1'b1 && (pc_inc === 1'b1 || reg_pc_load === 1'b1)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_exec", {21'd0, obs_exec()}, 32'h7ff);
      end else begin
        logic [10:0] e;
        e = sb_q.pop_front();
        check("exec", {21'd0, obs_exec()}, {21'd0, e});
        $display("exec %0d cyc=%0d sel=%b imm=%h a=%b b=%b io=%b pc=%b inc=%b",
                 exec_n, cyc, alu_data_sel, imm, reg_a_load, reg_b_load,
                 reg_io_load, reg_pc_load, pc_inc);
        exec_n++;
        prev_exec = last_exec;
        last_exec = cyc;
      end
    end
  end

  // Waits for fetch_req, holds off the ack for delay-1 request cycles, then hands over the word.
  task automatic fetch_instr(input logic [7:0] w, input int delay);
    int n = 0;
    while (bus.fetch_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.fetch_req !== 1'b1) begin
      check("fetch_req_timeout", {31'd0, bus.fetch_req}, 32'd1);
      return;
    end
    for (int i = 1; i < delay; i++) begin
      @(negedge clk);
      check("fetch_hold", {29'd0, bus.fetch_req, pc_inc, reg_a_load}, 32'b100);
    end
    bus.instr     = w;
    bus.fetch_ack = 1'b1;
    @(negedge clk);
    bus.fetch_ack = 1'b0;
  endtask

  task automatic wait_exec();
    int n = 0;
    while (sb_q.size() != 0 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("exec_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic run(input logic [7:0] w, input logic [10:0] e, input int delay);
    sb_q.push_back(e);
    fetch_instr(w, delay);
    wait_exec();
  endtask

  logic [7:0]  tbl_w[11] = '{8'h90, 8'hB9, 8'hF3, 8'hA5, 8'h2C, 8'h4D, 8'h61, 8'h5E,
                              8'h7A, 8'hC4, 8'hD2};
  logic [10:0] tbl_e[11];

  initial begin
    tbl_e[0]  = mk(2'b01, 4'h0, 0, 0, 1, 0, 1);
    tbl_e[1]  = mk(2'b11, 4'h9, 0, 0, 1, 0, 1);
    tbl_e[2]  = mk(2'b11, 4'h3, 0, 0, 0, 1, 0);
    tbl_e[3]  = mk(2'b11, 4'h5, 0, 0, 0, 0, 1);
    tbl_e[4]  = mk(2'b10, 4'hC, 1, 0, 0, 0, 1);
    tbl_e[5]  = mk(2'b00, 4'hD, 0, 1, 0, 0, 1);
    tbl_e[6]  = mk(2'b10, 4'h1, 0, 1, 0, 0, 1);
    tbl_e[7]  = mk(2'b01, 4'hE, 0, 1, 0, 0, 1);
    tbl_e[8]  = mk(2'b11, 4'hA, 0, 1, 0, 0, 1);
    tbl_e[9]  = mk(2'b11, 4'h4, 0, 0, 0, 0, 1);
    tbl_e[10] = mk(2'b11, 4'h2, 0, 0, 0, 0, 1);

    n_reset       = 1'b0;
    alu_carry     = 1'b0;
    bus.fetch_ack = 1'b0;
    bus.instr     = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_vals", {18'd0, obs_all()}, {18'd0, 1'b0, 2'b11, 4'h0, 5'b00000, 2'b00});

    // Ack tied high from release: two back-to-back MOV A,5 executions.
    n_reset       = 1'b1;
    bus.fetch_ack = 1'b1;
    bus.instr     = 8'h35;
    sb_q.push_back(mk(2'b11, 4'h5, 1, 0, 0, 0, 1));
    sb_q.push_back(mk(2'b11, 4'h5, 1, 0, 0, 0, 1));
    @(negedge clk);
    check("fetch_req_cycle1", {cyc[30:0], bus.fetch_req}, {31'd1, 1'b1});
    wait_exec();
    check("first_exec_cycle", prev_exec, 32'd3);
    check("period_ack_high", last_exec - prev_exec, 32'd3);
    bus.fetch_ack = 1'b0;

    // Ack arrives in the 4th request cycle.
    run(8'h12, mk(2'b01, 4'h2, 1, 0, 0, 0, 1), 4);
    check("period_ack_delay4", last_exec - prev_exec, 32'd6);

    // Carry set by ADD, so JNC falls through.
    alu_carry = 1'b1;
    run(8'h03, mk(2'b00, 4'h3, 1, 0, 0, 0, 1), 1);
    @(negedge clk);
    check("carry_after_add1", {31'd0, carry_flag}, 32'd1);
    run(8'hE7, mk(2'b11, 4'h7, 0, 0, 0, 0, 1), 1);

    // Carry clear, so JNC jumps.
    alu_carry = 1'b0;
    run(8'h01, mk(2'b00, 4'h1, 1, 0, 0, 0, 1), 1);
    @(negedge clk);
    check("carry_after_add0", {31'd0, carry_flag}, 32'd0);
    run(8'hE7, mk(2'b11, 4'h7, 0, 0, 0, 1, 0), 1);

    for (int i = 0; i < 11; i++) begin
      run(tbl_w[i], tbl_e[i], 1 + (i % 2));
    end

    // HALT: no further fetches until reset.
    fetch_instr(8'h80, 1);
    @(negedge clk);
    check("halted_entry", {30'd0, halted, bus.fetch_req}, 32'b10);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_hold", {29'd0, halted, bus.fetch_req, pc_inc}, 32'b100);
    end
    n_reset = 1'b0;
    #1;
    check("halt_reset", {18'd0, obs_all()}, {18'd0, 1'b0, 2'b11, 4'h0, 5'b00000, 2'b00});
    @(negedge clk);
    n_reset = 1'b1;
    alu_carry = 1'b1;
    run(8'h72, mk(2'b11, 4'h2, 0, 1, 0, 0, 1), 1);
    @(negedge clk);
    check("resume_carry", {31'd0, carry_flag}, 32'd1);

    // Reset lands in the middle of ADD B,3's EXEC cycle.
    fetch_instr(8'h53, 1);
    @(posedge clk);
    #1;
    check("exec_reached", {31'd0, reg_b_load}, 32'd1);
    #1;
    n_reset = 1'b0;
    #1;
    check("mid_exec_reset", {18'd0, obs_all()}, {18'd0, 1'b0, 2'b11, 4'h0, 5'b00000, 2'b00});
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
